// File: rtl/dist_ram_pkg.sv
// rtl/dist_ram_pkg.sv - shared types, constants and lane merge for the distributed dual-port RAM
package dist_ram_pkg;

    localparam int LANE_W     = 4;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_LANES  = MAX_DATA_W / LANE_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Callers zero-extend narrower words into MAX_DATA_W and truncate the result back.
    function automatic logic [MAX_DATA_W-1:0] lane_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_LANES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (be[i]) begin
                merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dist_ram_clr_seq.sv
// rtl/dist_ram_clr_seq.sv - zero-fill sweep sequencer: IDLE/CLEAR FSM plus address counter
module dist_ram_clr_seq
    import dist_ram_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam clr_state_t        RST_STATE = (CLR_ON_RST != 0) ? CLEAR : IDLE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter wraps to zero on the same edge that writes the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == CLEAR);
        clr_we   = (state_q == CLEAR);
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/dist_dpram_ctl.sv
// rtl/dist_dpram_ctl.sv - parametrised dual-port distributed RAM with lane writes, optional registered read and clear sweep
module dist_dpram_ctl
    import dist_ram_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int ADDR_W     = 4,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE   = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic                     WCK,
    input  logic                     RST,
    input  logic                     WRE,
    input  logic [DATA_W/4-1:0]      WBE,
    input  logic [ADDR_W-1:0]        WAD,
    input  logic [DATA_W-1:0]        DI,
    input  logic [ADDR_W-1:0]        RAD,
    input  logic                     RE,
    input  logic                     CLR_REQ,
    output logic [DATA_W-1:0]        DO,
    output logic                     BUSY
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] do_q, do_d;

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              user_wr;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_word;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    dist_ram_clr_seq #(
        .ADDR_W     (ADDR_W),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_clr_seq (
        .clk      (WCK),
        .rst      (RST),
        .clr_req  (CLR_REQ),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Only a clean 1 on WRE writes; X/Z and an all-zero lane mask are no-ops.
    always_comb begin
        user_wr = (WRE === 1'b1) && !busy && (|WBE);
        merged  = DATA_W'(lane_merge(MAX_DATA_W'(mem_q[WAD]), MAX_DATA_W'(DI), MAX_LANES'(WBE)));
        rd_word = mem_q[RAD];
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = WAD;
        wr_data = merged;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (user_wr) begin
            wr_en   = 1'b1;
        end
    end

    always_ff @(posedge WCK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Same-address bypass returns the merged word; otherwise the pre-edge word is captured.
    always_comb begin
        do_d = do_q;
        if (busy) begin
            do_d = '0;
        end else if (RE) begin
            if ((RDW_MODE != 0) && user_wr && (RAD == WAD)) begin
                do_d = merged;
            end else begin
                do_d = rd_word;
            end
        end
    end

    always_ff @(posedge WCK or posedge RST) begin
        if (RST) begin
            do_q <= '0;
        end else begin
            do_q <= do_d;
        end
    end

    always_comb begin
        BUSY = busy;
        if (busy) begin
            DO = '0;
        end else if (OUT_REG != 0) begin
            DO = do_q;
        end else begin
            DO = rd_word;
        end
    end

endmodule
